// File: rtl/mult_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// The slave modport is the multiplier side.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add multiplier sequencer: one external 2*WIDTH adder pass per
// cycle, WIDTH cycles per product, valid/ready on both sides.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_seq_ctrl_if.slave     bus,
  input  logic               clr,
  output logic               busy,
  output logic [2*WIDTH-1:0] add_a,
  output logic [2*WIDTH-1:0] add_b,
  output logic               add_cin,
  input  logic [2*WIDTH-1:0] add_sum
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc, mcand, product_q;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));
  assign bus.product = product_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.in_valid) state_d = CALC;
        CALC:    if (last_iter) state_d = DONE;
        DONE:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
    add_a         = '0;
    add_b         = '0;
    add_cin       = 1'b0;
    if (state_q == CALC) begin
      add_a = acc;
      add_b = mplier[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.op_a};
            mplier <= bus.op_b;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= add_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) product_q <= add_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural 16-bit adder.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        busy;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin;

  int checks = 0;
  int errors = 0;

  mult_seq_ctrl_if #(.WIDTH(8)) bus ();

  mult_seq_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr     (clr),
    .busy    (busy),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum)
  );

  assign add_sum = add_a + add_b + {15'b0, add_cin};

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          stall;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                        input logic [15:0] exp);
    int lat;
    int k;
    logic [7:0]  m;
    logic [15:0] ea, eb;
    wait_ready();
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = 8'($urandom);
    bus.op_b     = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      k = lat - 1;
      if (k < 8) begin
        m  = (8'd1 << k) - 8'd1;
        ea = 16'(a) * 16'(b & m);
        eb = b[k] ? (16'(a) << k) : 16'h0;
        chk("calc_add_a", {16'b0, add_a}, {16'b0, ea});
        chk("calc_add_b", {16'b0, add_b}, {16'b0, eb});
        chk("calc_add_cin", {31'b0, add_cin}, 32'd0);
        chk("calc_busy_ready", {30'b0, busy, bus.in_ready}, 32'd2);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 9);
    chk("done_product", {16'b0, bus.product}, {16'b0, exp});
    chk("done_add_ab", {add_a, add_b}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_product", {16'b0, bus.product}, {16'b0, exp});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("post_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("post_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("post_product", {16'b0, bus.product}, {16'b0, exp});
  endtask

  task automatic chk_idle(input string name, input logic [15:0] exp_p);
    chk({name, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
    chk({name, "_valid_busy"}, {30'b0, bus.out_valid, busy}, 32'd0);
    chk({name, "_product"}, {16'b0, bus.product}, {16'b0, exp_p});
    chk({name, "_adder"}, {add_a, add_b}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'h0F, 0,  16'h00E1};
    vecs[1] = '{8'hFF, 8'hFF, 0,  16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 0,  16'h0000};
    vecs[3] = '{8'h01, 8'h80, 0,  16'h0080};
    vecs[4] = '{8'h12, 8'h34, 20, 16'h03A8};
    vecs[5] = '{8'h03, 8'h05, 1,  16'h000F};
    vecs[6] = '{8'h80, 8'h80, 2,  16'h4000};
    vecs[7] = '{8'hFF, 8'h01, 0,  16'h00FF};
    vecs[8] = '{8'hAA, 8'h55, 3,  16'h3872};
    vecs[9] = '{8'h01, 8'hFF, 0,  16'h00FF};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;

    #12;
    chk_idle("reset", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].exp);

    // clr on the fourth CALC cycle: back to IDLE, last product kept
    wait_ready();
    bus.op_a = 8'h0F; bus.op_b = 8'h0F; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("clr_pre_busy", {31'b0, busy}, 32'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_idle("clr", 16'h00FF);
    repeat (12) begin
      @(posedge clk); #1;
      chk("clr_no_valid", {30'b0, bus.out_valid, busy}, 32'd0);
    end

    // clr together with in_valid in IDLE: operand dropped
    @(negedge clk);
    bus.op_a = 8'h22; bus.op_b = 8'h33; bus.in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; clr = 1'b0;
    chk_idle("clr_accept", 16'h00FF);

    // async reset mid-CALC
    wait_ready();
    bus.op_a = 8'h77; bus.op_b = 8'h99; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_pre_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("rst_no_valid", {30'b0, bus.out_valid, busy}, 32'd0);
    end

    run_op(8'h03, 8'h05, 0, 16'h000F);

    for (int n = 0; n < 200; n++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(a, b, int'($urandom_range(0, 3)), 16'(a) * 16'(b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
